reg_scoreboard: RTL and testbench

//   Issue-side hazard controller for the register-read stage. Tracks in-flight writes
//   per architectural register and stalls decode->register-read while an operand is pending.
//   - Fixed-latency ops (ALU, multi-cycle ALU) retire on an internal countdown.
//   - Variable-latency ops (loads) retire on an explicit writeback.

---
 rtl/reg_scoreboard_pkg.sv | 36 +++
 rtl/reg_scoreboard_entry.sv | 56 +++++
 rtl/reg_scoreboard.sv | 104 ++++++++++
 tb/tb_reg_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared widths, index types and helpers for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned LAT_W  = 2;
  localparam int unsigned REG_AW = $clog2(NREGS);
  localparam int unsigned CNT_W  = REG_AW + 1;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0]  lat_t;
  typedef logic [NREGS-1:0]  reg_mask_t;
  typedef logic [CNT_W-1:0]  reg_cnt_t;

  // Decode-stage request as seen by the scoreboard.
  typedef struct packed {
    logic     valid;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     use_rs;
    logic     use_rt;
    reg_idx_t rd;
    logic     wr;
    lat_t     lat;
  } dec_req_t;

  // Number of set bits in a per-register mask.
  function automatic reg_cnt_t popcount(input reg_mask_t m);
    reg_cnt_t c;
    c = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      c = c + reg_cnt_t'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// Pending-write tracker for one architectural register: fixed-latency
// countdown plus a variable-latency (waiting-for-writeback) flag.
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_iss,
  input  lat_t i_lat,
  input  logic i_wb,
  output logic o_var,
  output logic o_busy_nxt
);

  lat_t r_cnt;
  lat_t w_cnt_nxt;
  logic r_var;
  logic w_var_nxt;

  // Next state: a new issue wins over writeback and countdown on this register.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_var_nxt = r_var;
    if (i_iss) begin
      if (i_lat != '0) begin
        w_cnt_nxt = i_lat;
        w_var_nxt = 1'b0;
      end else begin
        w_cnt_nxt = '0;
        w_var_nxt = 1'b1;
      end
    end else begin
      if (i_wb && r_var) begin
        w_var_nxt = 1'b0;
      end
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - lat_t'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_var <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_var <= w_var_nxt;
    end
  end

  assign o_var      = r_var;
  assign o_busy_nxt = (w_cnt_nxt != '0) | w_var_nxt;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller: tracks in-flight writes per register and
// holds decode while an operand or destination is still pending.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter bit R0_FIXED = 1'b0
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      dec_valid,
  input  reg_idx_t  dec_rs,
  input  reg_idx_t  dec_rt,
  input  logic      dec_use_rs,
  input  logic      dec_use_rt,
  input  reg_idx_t  dec_rd,
  input  logic      dec_wr,
  input  lat_t      dec_lat,
  input  logic      exec_stall,
  input  logic      exec_flush,
  input  logic      wb_valid,
  input  reg_idx_t  wb_rd,
  output logic      sb_stall,
  output reg_mask_t sb_busy,
  output reg_cnt_t  sb_inflight,
  output logic      sb_err
);

  dec_req_t  w_dec;
  logic      w_haz;
  logic      w_r0_block;
  logic      w_iss;
  logic      w_err_set;
  reg_mask_t w_iss_vec;
  reg_mask_t w_wb_vec;
  reg_mask_t w_var;
  reg_mask_t w_busy_nxt;
  reg_mask_t r_busy;
  reg_cnt_t  r_inflight;
  logic      r_err;

  assign w_dec = '{valid:  dec_valid,
                   rs:     dec_rs,
                   rt:     dec_rt,
                   use_rs: dec_use_rs,
                   use_rt: dec_use_rt,
                   rd:     dec_rd,
                   wr:     dec_wr,
                   lat:    dec_lat};

  // Hazard check against current busy state (RAW on rs/rt, WAW on rd) and issue decision.
  always_comb begin
    w_haz      = w_dec.valid & ((w_dec.use_rs & r_busy[w_dec.rs]) |
                                (w_dec.use_rt & r_busy[w_dec.rt]) |
                                (w_dec.wr     & r_busy[w_dec.rd]));
    w_r0_block = R0_FIXED && (w_dec.rd == '0);
    sb_stall   = w_haz | exec_stall;
    w_iss      = w_dec.valid & ~sb_stall & ~exec_flush & w_dec.wr & ~w_r0_block;
  end

  // One-hot issue/writeback strobes and writeback-to-idle detection.
  always_comb begin
    w_iss_vec = '0;
    w_wb_vec  = '0;
    if (w_iss) begin
      w_iss_vec[w_dec.rd] = 1'b1;
    end
    if (wb_valid) begin
      w_wb_vec[wb_rd] = 1'b1;
    end
    w_err_set = wb_valid & ~w_var[wb_rd];
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_entry
    sb_entry u_entry (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_iss      (w_iss_vec[g]),
      .i_lat      (w_dec.lat),
      .i_wb       (w_wb_vec[g]),
      .o_var      (w_var[g]),
      .o_busy_nxt (w_busy_nxt[g])
    );
  end

  // Registered busy mask, in-flight count and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy     <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_inflight <= popcount(w_busy_nxt);
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign sb_busy     = r_busy;
  assign sb_inflight = r_inflight;
  assign sb_err      = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios then random traffic, both
// checked against a deadline/pending-flag model, on R0_FIXED=0 and =1 copies.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     i_reset;
  logic     dec_valid, dec_use_rs, dec_use_rt, dec_wr;
  reg_idx_t dec_rs, dec_rt, dec_rd, wb_rd;
  lat_t     dec_lat;
  logic     exec_stall, exec_flush, wb_valid;

  logic      o_stall [2];
  reg_mask_t o_busy  [2];
  reg_cnt_t  o_infl  [2];
  logic      o_err   [2];

  reg_scoreboard #(.R0_FIXED(1'b0)) dut (
    .i_clk(clk), .i_reset(i_reset), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .dec_lat(dec_lat), .exec_stall(exec_stall), .exec_flush(exec_flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .sb_stall(o_stall[0]), .sb_busy(o_busy[0]), .sb_inflight(o_infl[0]),
    .sb_err(o_err[0]));

  reg_scoreboard #(.R0_FIXED(1'b1)) dut_r0 (
    .i_clk(clk), .i_reset(i_reset), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .dec_lat(dec_lat), .exec_stall(exec_stall), .exec_flush(exec_flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .sb_stall(o_stall[1]), .sb_busy(o_busy[1]), .sb_inflight(o_infl[1]),
    .sb_err(o_err[1]));

  int checks   = 0;
  int failures = 0;

  // Model: a register is busy while the edge count is below its free-at
  // deadline, or while it awaits a writeback.
  int unsigned cyc = 0;
  int unsigned m_free [2][NREGS];
  bit          m_pend [2][NREGS];
  bit          m_err  [2];

  function automatic bit m_busy(int k, int r);
    return (cyc < m_free[k][r]) || m_pend[k][r];
  endfunction

  task automatic check1(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        m_free[k][r] = 0;
        m_pend[k][r] = 1'b0;
      end
      m_err[k] = 1'b0;
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_use_rs = 0; dec_use_rt = 0; dec_wr = 0;
    dec_rs = '0; dec_rt = '0; dec_rd = '0; dec_lat = '0;
    exec_stall = 0; exec_flush = 0; wb_valid = 0; wb_rd = '0;
  endtask

  task automatic dec(int rs, bit urs, int rt, bit urt, int rd, bit wr, int lat);
    dec_valid = 1; dec_rs = reg_idx_t'(rs); dec_use_rs = urs;
    dec_rt = reg_idx_t'(rt); dec_use_rt = urt;
    dec_rd = reg_idx_t'(rd); dec_wr = wr; dec_lat = lat_t'(lat);
  endtask

  // One clock: check the combinational stall, advance the model, check registered outputs.
  task automatic step();
    bit iss [2];
    bit haz, exp_stall;
    int unsigned newc;
    reg_mask_t exp_mask;
    int cnt;
    #1;
    for (int k = 0; k < 2; k++) begin
      haz = dec_valid && ((dec_use_rs && m_busy(k, int'(dec_rs))) ||
                          (dec_use_rt && m_busy(k, int'(dec_rt))) ||
                          (dec_wr     && m_busy(k, int'(dec_rd))));
      exp_stall = haz || exec_stall;
      check1($sformatf("stall[%0d]", k), 32'(o_stall[k]), 32'(exp_stall));
      iss[k] = dec_valid && !exp_stall && !exec_flush && dec_wr && !(k == 1 && dec_rd == '0);
    end
    newc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (i_reset) begin
        for (int r = 0; r < int'(NREGS); r++) begin
          m_free[k][r] = 0;
          m_pend[k][r] = 1'b0;
        end
        m_err[k] = 1'b0;
      end else begin
        if (wb_valid) begin
          if (m_pend[k][wb_rd]) m_pend[k][wb_rd] = 1'b0;
          else m_err[k] = 1'b1;
        end
        if (iss[k]) begin
          if (dec_lat != '0) begin
            m_free[k][dec_rd] = newc + int'(dec_lat);
            m_pend[k][dec_rd] = 1'b0;
          end else begin
            m_free[k][dec_rd] = 0;
            m_pend[k][dec_rd] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = newc;
    for (int k = 0; k < 2; k++) begin
      exp_mask = '0;
      cnt = 0;
      for (int r = 0; r < int'(NREGS); r++) begin
        exp_mask[r] = m_busy(k, r);
        if (exp_mask[r]) cnt++;
      end
      check1($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(exp_mask));
      check1($sformatf("inflight[%0d]", k), 32'(o_infl[k]), 32'(cnt));
      check1($sformatf("err[%0d]", k), 32'(o_err[k]), 32'(m_err[k]));
    end
  endtask

  initial begin
    int p;
    idle();
    model_clear();
    i_reset = 1;
    repeat (2) @(posedge clk);
    #1;
    step();
    check1("reset_busy", 32'(o_busy[0]), 32'h0);
    check1("reset_inflight", 32'(o_infl[0]), 32'h0);
    check1("reset_err", 32'(o_err[0]), 32'h0);
    i_reset = 0;

    // Fixed latency 2 to r3, then a reader of r3.
    dec(0, 0, 0, 0, 3, 1, 2); step();
    check1("t1_busy3", 32'(o_busy[0][3]), 32'h1);
    dec(3, 1, 0, 0, 0, 0, 0); step(); step(); step();
    idle(); step();

    // Load to r5, dependent on rt=5 held until after the writeback.
    dec(0, 0, 0, 0, 5, 1, 0); step();
    dec(0, 0, 5, 1, 6, 1, 1);
    repeat (6) step();
    check1("t2_inflight", 32'(o_infl[0]), 32'h1);
    wb_valid = 1; wb_rd = 5; step();
    wb_valid = 0; step();
    idle(); step(); step();
    check1("t2_drained", 32'(o_infl[0]), 32'h0);

    // Load to r7 pending, then a new r7 write together with wb to r7.
    dec(0, 0, 0, 0, 7, 1, 0); step();
    idle(); step();
    dec(0, 0, 0, 0, 7, 1, 0); wb_valid = 1; wb_rd = 7; step();
    wb_valid = 0; step();
    idle(); wb_valid = 1; wb_rd = 7; step();
    idle(); step();

    // Flush suppresses issue to r2 while older r4 keeps counting.
    dec(0, 0, 0, 0, 4, 1, 2); step();
    dec(0, 0, 0, 0, 2, 1, 3); exec_flush = 1; step();
    check1("t4_busy2", 32'(o_busy[0][2]), 32'h0);
    idle(); step(); step();

    // Writeback to idle r9 sets the sticky error; reset clears it.
    wb_valid = 1; wb_rd = 9; step();
    idle(); step(); step();
    check1("t5_err_sticky", 32'(o_err[0]), 32'h1);
    i_reset = 1; step();
    i_reset = 0;
    check1("t5_err_cleared", 32'(o_err[0]), 32'h0);

    // Writes to r0 and a bare exec_stall.
    dec(0, 0, 0, 0, 0, 1, 3); step();
    check1("t6_r0_busy", 32'(o_busy[1][0]), 32'h0);
    dec(0, 1, 0, 0, 1, 0, 0); step();
    idle(); dec(0, 0, 0, 0, 1, 1, 1); exec_stall = 1; step();
    idle(); repeat (4) step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      i_reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) != 0) begin
        dec(int'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)));
      end
      exec_stall = ($urandom_range(0, 7) == 0);
      exec_flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        wb_valid = 1;
        wb_rd = reg_idx_t'($urandom_range(0, NREGS - 1));
        if ($urandom_range(0, 7) != 0) begin
          p = int'($urandom_range(0, NREGS - 1));
          for (int j = 0; j < int'(NREGS); j++) begin
            if (m_pend[0][(p + j) % NREGS]) begin
              wb_rd = reg_idx_t'((p + j) % NREGS);
              break;
            end
          end
        end
      end
      step();
    end
    i_reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
